// File: rtl/i2c_master_word_if.sv
// rtl/i2c_master_word_if.sv - control handshake and open-drain pad bundle for i2c_master_word
//
// Purpose: groups the word-level start/done control side and the SCL/SDA pad
//          signals of the I2C word master into one interface.
// Ports (signals):
//   start, rw, addr, nbytes, data_in   request and operands (to master)
//   data_out, busy, done, nack         results and status (from master)
//   scl_oe, sda_oe                     1 = pull pad low (from master)
//   scl_i, sda_i                       pad line levels (to master)
// Modports: master (the RTL block), slave (the requesting/pad side).
interface i2c_master_word_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NB_WIDTH   = 3
);
    logic                  start;
    logic                  rw;
    logic [6:0]            addr;
    logic [NB_WIDTH-1:0]   nbytes;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  busy;
    logic                  done;
    logic                  nack;
    logic                  scl_oe;
    logic                  scl_i;
    logic                  sda_oe;
    logic                  sda_i;

    modport master (
        input  start, rw, addr, nbytes, data_in, scl_i, sda_i,
        output data_out, busy, done, nack, scl_oe, sda_oe
    );

    modport slave (
        output start, rw, addr, nbytes, data_in, scl_i, sda_i,
        input  data_out, busy, done, nack, scl_oe, sda_oe
    );
endinterface

// File: rtl/i2c_master_word.sv
// rtl/i2c_master_word.sv - I2C bus master moving 1..DATA_WIDTH/8 bytes per transaction
//
// Purpose: START, 7-bit address + R/W, data bytes with ACK/NACK checking, STOP.
// Ports:
//   clk   system clock
//   rst   asynchronous reset, active-low
//   bus   i2c_master_word_if.master: start/rw/addr/nbytes/data_in in,
//         data_out/busy/done/nack out, scl_oe/sda_oe pad pull-downs, scl_i/sda_i line levels
// Parameters: DATA_WIDTH (multiple of 8), CLK_DIV (clk cycles per SCL quarter), NB_WIDTH.
// Optional feature macro: I2C_CLK_STRETCH_EN (slave clock stretching in Q2/Q3).
module i2c_master_word #(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 4,
    parameter int NB_WIDTH   = 3
) (
    input  logic                clk,
    input  logic                rst,
    i2c_master_word_if.master   bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int QW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // The start cycle itself is counted as the first tick of the START slot,
    // so the accepted request lands one tick into the slot.
    localparam logic [QW-1:0] Q_INIT   = (CLK_DIV > 1) ? QW'(1) : '0;
    localparam logic [1:0]    QTR_INIT = (CLK_DIV > 1) ? 2'd0 : 2'd1;
    localparam logic [NB_WIDTH-1:0] NB_ONE = NB_WIDTH'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR_BYTE,
        S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [QW-1:0]         q_cnt_q, q_cnt_d;
    logic [1:0]            quarter_q, quarter_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [NB_WIDTH-1:0]   byte_cnt_q, byte_cnt_d;
    logic [NB_WIDTH-1:0]   nbytes_q, nbytes_d;
    logic [7:0]            addr_sh_q, addr_sh_d;
    logic                  rw_q, rw_d;
    logic [DATA_WIDTH-1:0] wr_sh_q, wr_sh_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  ack_q, ack_d;
    logic                  nack_q, nack_d;
    logic                  done_q, done_d;

    logic                  scl_oe_c, sda_oe_c;
    logic                  hold;
    logic                  q_last;
    logic                  last_byte;
    logic [NB_WIDTH-1:0]   nb_eff;

    assign nb_eff    = (bus.nbytes == '0) ? NB_WIDTH'(BYTES) : bus.nbytes;
    assign q_last    = (q_cnt_q == QW'(CLK_DIV - 1));
    assign last_byte = ((byte_cnt_q + NB_ONE) == nbytes_q);

`ifdef I2C_CLK_STRETCH_EN
    // SCL released by us but still low: a slave is stretching the clock.
    assign hold = quarter_q[1] && !scl_oe_c && !bus.scl_i;
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        q_cnt_d    = q_cnt_q;
        quarter_d  = quarter_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        nbytes_d   = nbytes_q;
        addr_sh_d  = addr_sh_q;
        rw_d       = rw_q;
        wr_sh_d    = wr_sh_q;
        data_out_d = data_out_q;
        ack_d      = ack_q;
        nack_d     = nack_q;
        done_d     = 1'b0;

        if (state_q == S_IDLE) begin
            q_cnt_d   = '0;
            quarter_d = 2'd0;
            // A start coinciding with the done pulse is dropped.
            if (bus.start && !done_q) begin
                state_d    = S_START;
                q_cnt_d    = Q_INIT;
                quarter_d  = QTR_INIT;
                rw_d       = bus.rw;
                addr_sh_d  = {bus.addr, bus.rw};
                nbytes_d   = nb_eff;
                // Left-justify the low nb_eff bytes so the first byte sits at the MSB.
                wr_sh_d    = bus.data_in << (DATA_WIDTH - 8 * int'(nb_eff));
                byte_cnt_d = '0;
                bit_cnt_d  = 3'd7;
                data_out_d = '0;
                nack_d     = 1'b0;
            end
        end else if (!hold) begin
            if (!q_last) begin
                q_cnt_d = q_cnt_q + QW'(1);
            end else begin
                q_cnt_d   = '0;
                quarter_d = quarter_q + 2'd1;
                if (quarter_q == 2'd2) begin
                    ack_d = bus.sda_i;
                    if (state_q == S_RD_BYTE) begin
                        data_out_d = {data_out_q[DATA_WIDTH-2:0], bus.sda_i};
                    end
                end
                if (quarter_q == 2'd3) begin
                    unique case (state_q)
                        S_START: state_d = S_ADDR;
                        S_ADDR: begin
                            addr_sh_d = {addr_sh_q[6:0], 1'b0};
                            if (bit_cnt_q == 3'd0) state_d = S_ADDR_ACK;
                            else                   bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                        S_ADDR_ACK: begin
                            bit_cnt_d = 3'd7;
                            if (ack_q) begin
                                nack_d  = 1'b1;
                                state_d = S_STOP;
                            end else begin
                                state_d = rw_q ? S_RD_BYTE : S_WR_BYTE;
                            end
                        end
                        S_WR_BYTE: begin
                            wr_sh_d = {wr_sh_q[DATA_WIDTH-2:0], 1'b0};
                            if (bit_cnt_q == 3'd0) state_d = S_WR_ACK;
                            else                   bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                        S_WR_ACK: begin
                            bit_cnt_d = 3'd7;
                            if (ack_q) begin
                                nack_d  = 1'b1;
                                state_d = S_STOP;
                            end else if (last_byte) begin
                                state_d = S_STOP;
                            end else begin
                                byte_cnt_d = byte_cnt_q + NB_ONE;
                                state_d    = S_WR_BYTE;
                            end
                        end
                        S_RD_BYTE: begin
                            if (bit_cnt_q == 3'd0) state_d = S_RD_ACK;
                            else                   bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                        S_RD_ACK: begin
                            bit_cnt_d = 3'd7;
                            if (last_byte) begin
                                state_d = S_STOP;
                            end else begin
                                byte_cnt_d = byte_cnt_q + NB_ONE;
                                state_d    = S_RD_BYTE;
                            end
                        end
                        S_STOP: begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        end
    end

    // Pad drive: SCL is pulled low in Q0/Q1 of every bit slot; START/STOP shape SDA around a high SCL.
    always_comb begin
        scl_oe_c = 1'b0;
        sda_oe_c = 1'b0;
        unique case (state_q)
            S_START:    sda_oe_c = quarter_q[1];
            S_ADDR: begin
                scl_oe_c = !quarter_q[1];
                sda_oe_c = !addr_sh_q[7];
            end
            S_ADDR_ACK, S_WR_ACK, S_RD_BYTE: scl_oe_c = !quarter_q[1];
            S_WR_BYTE: begin
                scl_oe_c = !quarter_q[1];
                sda_oe_c = !wr_sh_q[DATA_WIDTH-1];
            end
            S_RD_ACK: begin
                scl_oe_c = !quarter_q[1];
                sda_oe_c = !last_byte;
            end
            S_STOP: begin
                scl_oe_c = !quarter_q[1];
                sda_oe_c = (quarter_q != 2'd3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            q_cnt_q    <= '0;
            quarter_q  <= 2'd0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= '0;
            nbytes_q   <= '0;
            addr_sh_q  <= 8'd0;
            rw_q       <= 1'b0;
            wr_sh_q    <= '0;
            data_out_q <= '0;
            ack_q      <= 1'b0;
            nack_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_cnt_q    <= q_cnt_d;
            quarter_q  <= quarter_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            nbytes_q   <= nbytes_d;
            addr_sh_q  <= addr_sh_d;
            rw_q       <= rw_d;
            wr_sh_q    <= wr_sh_d;
            data_out_q <= data_out_d;
            ack_q      <= ack_d;
            nack_q     <= nack_d;
            done_q     <= done_d;
        end
    end

    assign bus.scl_oe   = scl_oe_c;
    assign bus.sda_oe   = sda_oe_c;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.nack     = nack_q;
    assign bus.data_out = data_out_q;
endmodule
